// File: rtl/bp_nonsynth_stall_counter_bank.sv
// Per-reason stall histogram bank fed by the core profiler's final-stage reason.
// Live counters accumulate each enabled cycle; a host reads snapshotted shadows over a valid/ready port.
module bp_nonsynth_stall_counter_bank #(
  parameter int num_reasons_p   = 21,
  parameter int reason_width_p  = 5,
  parameter int counter_width_p = 32,
  localparam int addr_width_lp  = $clog2(num_reasons_p + 3)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       en_i,
  input  logic                       commit_v_i,
  input  logic                       stall_v_i,
  input  logic [reason_width_p-1:0]  stall_reason_i,
  input  logic                       clear_i,
  input  logic                       snap_i,
  input  logic                       rd_v_i,
  input  logic [addr_width_lp-1:0]   rd_addr_i,
  output logic                       rd_ready_o,
  output logic                       rd_data_v_o,
  output logic [counter_width_p-1:0] rd_data_o,
  output logic                       rd_err_o,
  input  logic                       rd_yumi_i
);

  localparam int num_ctrs_lp    = num_reasons_p + 3;
  localparam int instr_idx_lp   = num_reasons_p;
  localparam int unknown_idx_lp = num_reasons_p + 1;
  localparam int total_idx_lp   = num_reasons_p + 2;

  typedef logic [counter_width_p-1:0] ctr_t;

  ctr_t live_r   [num_ctrs_lp];
  ctr_t shadow_r [num_ctrs_lp];

  logic [num_reasons_p-1:0] reason_hit;
  logic [num_ctrs_lp-1:0]   inc;

  // One-hot decode of the stall code; out-of-range codes leave every bit low.
  always_comb begin
    for (int i = 0; i < num_reasons_p; i++) begin
      reason_hit[i] = stall_v_i && (stall_reason_i == reason_width_p'(i));
    end
  end

  // Exactly one class counter plus the total counter bump on each enabled cycle.
  always_comb begin
    // NOTE: defaulting every bit first keeps this purely combinational; a missed path would infer a latch.
    inc = '0;
    if (en_i) begin
      inc[total_idx_lp] = 1'b1;
      if (commit_v_i) begin
        inc[instr_idx_lp] = 1'b1;
      end else if (|reason_hit) begin
        inc[num_reasons_p-1:0] = reason_hit;
      end else begin
        inc[unknown_idx_lp] = 1'b1;
      end
    end
  end

  // Live and shadow banks. Snap samples the pre-edge live value, so a same-cycle
  // clear or increment never leaks into the shadow.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      // NOTE: these arrays are small flop banks, not RAM, and a host may read them right after reset, so they are reset.
      for (int i = 0; i < num_ctrs_lp; i++) begin
        live_r[i]   <= '0;
        shadow_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < num_ctrs_lp; i++) begin
        if (snap_i) begin
          shadow_r[i] <= live_r[i];
        end
        if (clear_i) begin
          live_r[i] <= '0;
        end else if (inc[i] && (live_r[i] != '1)) begin
          live_r[i] <= live_r[i] + ctr_t'(1);
        end
      end
    end
  end

  // Read port: one-entry response register that can be refilled in the cycle it drains.
  logic                 resp_v_r;
  logic                 resp_err_r;
  ctr_t                 resp_data_r;
  logic                 rd_accept;
  logic                 addr_in_range;
  ctr_t                 rd_sel_data;

  assign addr_in_range = ({1'b0, rd_addr_i} < (addr_width_lp + 1)'(num_ctrs_lp));
  assign rd_ready_o    = ~resp_v_r | rd_yumi_i;
  assign rd_accept     = rd_v_i & rd_ready_o;

  always_comb begin
    rd_sel_data = '0;
    if (addr_in_range) begin
      rd_sel_data = shadow_r[rd_addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_v_r    <= 1'b0;
      resp_err_r  <= 1'b0;
      resp_data_r <= '0;
    end else if (rd_accept) begin
      resp_v_r    <= 1'b1;
      resp_err_r  <= ~addr_in_range;
      resp_data_r <= rd_sel_data;
    end else if (rd_yumi_i) begin
      // Idle outputs return to zero once the consumer has taken the response.
      resp_v_r    <= 1'b0;
      resp_err_r  <= 1'b0;
      resp_data_r <= '0;
    end
  end

  assign rd_data_v_o = resp_v_r;
  assign rd_data_o   = resp_data_r;
  assign rd_err_o    = resp_err_r;

endmodule
